// File: rtl/vga_frame_capture_if.sv
// VGA frame capture link: capture control, incoming VGA stream, image-RAM write port and status.
// master = stream source / system side (drives CAP_START and the VGA pins), slave = capture block.
// Signals: CAP_START, VGA_HS/VS/BLANK/R/G/B (to slave); RAM_WADDR/WDATA/WE, CAP_BUSY/DONE,
//          H_ACTIVE/V_ACTIVE, FRAME_ERR (from slave).
interface vga_frame_capture_if #(
    parameter int CNT_W = 10
);
    // capture control
    logic             CAP_START;
    // incoming VGA stream
    logic             VGA_HS;
    logic             VGA_VS;
    logic             VGA_BLANK;
    logic [7:0]       VGA_R;
    logic [7:0]       VGA_G;
    logic [7:0]       VGA_B;
    // image RAM write port
    logic [15:0]      RAM_WADDR;
    logic [7:0]       RAM_WDATA;
    logic             RAM_WE;
    // status
    logic             CAP_BUSY;
    logic             CAP_DONE;
    logic [CNT_W-1:0] H_ACTIVE;
    logic [CNT_W-1:0] V_ACTIVE;
    logic             FRAME_ERR;

    modport master (
        output CAP_START, VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B,
        input  RAM_WADDR, RAM_WDATA, RAM_WE,
        input  CAP_BUSY, CAP_DONE, H_ACTIVE, V_ACTIVE, FRAME_ERR
    );

    modport slave (
        input  CAP_START, VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B,
        output RAM_WADDR, RAM_WDATA, RAM_WE,
        output CAP_BUSY, CAP_DONE, H_ACTIVE, V_ACTIVE, FRAME_ERR
    );
endinterface

// File: rtl/vga_frame_capture.sv
// VGA frame capture: samples a VGA stream and writes one window of one frame into the 256x256x8 image RAM.
// Latency: a pixel at the pins is written 2 VGA_CLK edges later (input register + registered write port).
// Backpressure: none; the RAM accepts one write per cycle, stream is never stalled.
//
// Ports: VGA_CLK, rst_intern (async, active-high) plus vga_frame_capture_if.slave bus carrying
//        CAP_START, the VGA stream, the RAM write port (RAM_WADDR={line,pixel}, RAM_WDATA, RAM_WE)
//        and status (CAP_BUSY, CAP_DONE, H_ACTIVE, V_ACTIVE, FRAME_ERR).
// Build option: define CAPTURE_LUMA_EN to store (R + 2G + B) >> 2 instead of the G channel.
module vga_frame_capture #(
    parameter int unsigned WIN_X0 = 0,    // first captured active pixel per line
    parameter int unsigned WIN_Y0 = 0,    // first captured active line
    parameter int unsigned WIN_W  = 256,  // captured pixels per line (1..256)
    parameter int unsigned WIN_H  = 256,  // captured lines (1..256)
    parameter int unsigned CNT_W  = 10    // pixel/line counter and H/V_ACTIVE width
) (
    input logic                VGA_CLK,
    input logic                rst_intern,
    vga_frame_capture_if.slave bus
);

    localparam int unsigned    X_END = WIN_X0 + WIN_W;
    localparam int unsigned    Y_END = WIN_Y0 + WIN_H;
    localparam logic [CNT_W-1:0] X0_C = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0] Y0_C = CNT_W'(WIN_Y0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Input stage (S1) and previous-sample registers.
    // Line boundaries come from BLANK alone, so HS is not sampled.
    // S1 VS/BLANK reset to the same idle values as the previous-sample
    // registers so the first cycle after reset cannot see a false edge.
    // ------------------------------------------------------------------
    logic       vs_s1;
    logic       blank_s1;
    logic [7:0] g_s1;
    logic       vs_p;
    logic       blank_p;
`ifdef CAPTURE_LUMA_EN
    logic [7:0] r_s1;
    logic [7:0] b_s1;
`endif

    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            vs_s1    <= 1'b1;
            blank_s1 <= 1'b0;
            g_s1     <= 8'd0;
            vs_p     <= 1'b1;
            blank_p  <= 1'b0;
        end else begin
            vs_s1    <= bus.VGA_VS;
            blank_s1 <= bus.VGA_BLANK;
            g_s1     <= bus.VGA_G;
            vs_p     <= vs_s1;
            blank_p  <= blank_s1;
        end
    end

`ifdef CAPTURE_LUMA_EN
    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            r_s1 <= 8'd0;
            b_s1 <= 8'd0;
        end else begin
            r_s1 <= bus.VGA_R;
            b_s1 <= bus.VGA_B;
        end
    end
`endif

    logic vs_fall;
    logic line_end;

    assign vs_fall  = vs_p & ~vs_s1;
    assign line_end = blank_p & ~blank_s1;

    // ------------------------------------------------------------------
    // Pixel value stored in RAM
    // ------------------------------------------------------------------
    logic [7:0] pix_val;

`ifdef CAPTURE_LUMA_EN
    // 10 bits hold the worst case 255 + 510 + 255; truncating shift, no rounding.
    logic [9:0] luma_sum;
    assign luma_sum = {2'b00, r_s1} + {1'b0, g_s1, 1'b0} + {2'b00, b_s1};
    assign pix_val  = 8'(luma_sum >> 2);
`else
    assign pix_val  = g_s1;
`endif

    // ------------------------------------------------------------------
    // Position counters, running on the S1 stream.
    // pix_cnt is the index of the current S1 pixel within its line, so at
    // line_end it holds the length of the line that just finished.
    // A line with no active pixels never raises line_end and is not counted.
    // vs_fall wins over everything, even in the middle of a line.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;

    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            if (vs_fall || line_end) begin
                pix_cnt <= '0;
            end else if (blank_s1) begin
                pix_cnt <= pix_cnt + 1'b1;
            end

            if (vs_fall) begin
                line_cnt <= '0;
            end else if (line_end) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture state machine with registered status outputs
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] ref_len;   // length of the first line of the captured frame
    logic             ref_vld;
    logic [CNT_W-1:0] v_lat;     // line count at the terminating vs_fall

    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            state         <= IDLE;
            ref_len       <= '0;
            ref_vld       <= 1'b0;
            v_lat         <= '0;
            bus.CAP_BUSY  <= 1'b0;
            bus.CAP_DONE  <= 1'b0;
            bus.H_ACTIVE  <= '0;
            bus.V_ACTIVE  <= '0;
            bus.FRAME_ERR <= 1'b0;
        end else begin
            bus.CAP_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CAP_START) begin
                        state         <= ARM;
                        bus.CAP_BUSY  <= 1'b1;
                        bus.FRAME_ERR <= 1'b0;
                        ref_vld       <= 1'b0;
                        ref_len       <= '0;
                    end
                end

                ARM: begin
                    if (vs_fall) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (line_end) begin
                        if (!ref_vld) begin
                            ref_len <= pix_cnt;
                            ref_vld <= 1'b1;
                        end else if (pix_cnt != ref_len) begin
                            bus.FRAME_ERR <= 1'b1;
                        end
                    end
                    if (vs_fall) begin
                        state        <= DONE;
                        bus.CAP_DONE <= 1'b1;
                        // line_cnt clears on this same edge, so keep its value
                        // (including a line ending in this very cycle).
                        v_lat        <= line_cnt + CNT_W'(line_end);
                    end
                end

                DONE: begin
                    bus.H_ACTIVE <= ref_len;
                    bus.V_ACTIVE <= v_lat;
                    bus.CAP_BUSY <= 1'b0;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write path. Still CAPTURE during the terminating vs_fall cycle, so a
    // pixel arriving together with a malformed vs_fall is still written.
    // ------------------------------------------------------------------
    logic in_x;
    logic in_y;
    logic wr_en;

    assign in_x  = (32'(pix_cnt) >= WIN_X0) && (32'(pix_cnt) < X_END);
    assign in_y  = (32'(line_cnt) >= WIN_Y0) && (32'(line_cnt) < Y_END);
    assign wr_en = (state == CAPTURE) && blank_s1 && in_x && in_y;

    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            bus.RAM_WE    <= 1'b0;
            bus.RAM_WADDR <= 16'd0;
            bus.RAM_WDATA <= 8'd0;
        end else begin
            bus.RAM_WE <= wr_en;
            if (wr_en) begin
                bus.RAM_WADDR <= {8'(line_cnt - Y0_C), 8'(pix_cnt - X0_C)};
                bus.RAM_WDATA <= pix_val;
            end
        end
    end

endmodule
